// File: rtl/sprite_pkg.sv
// Shared types and default video geometry for the sprite motion controller.
package sprite_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int SPRITE_W = 64;
  localparam int SPRITE_H = 64;

  typedef logic [9:0] coord_t;

  // 1 = positive direction (right / down)
  typedef logic dir_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    COMMIT = 2'd2
  } motion_state_t;

endpackage

// File: rtl/sprite_motion_ctrl_axis_stepper.sv
// Combinational next-position calculator for one axis (auto bounce or manual).
module axis_stepper
  import sprite_pkg::*;
(
  input  coord_t     i_pos,
  input  logic [3:0] i_step,
  input  dir_t       i_dir,
  input  coord_t     i_max,
  input  logic       i_auto,
  input  logic       i_plus,
  input  logic       i_minus,
  output coord_t     o_next,
  output dir_t       o_next_dir,
  output logic       o_bounce
);

  logic signed [10:0] w_pos;
  logic signed [10:0] w_step;
  logic signed [10:0] w_max;
  logic signed [10:0] w_cand;

  // Signed 11-bit intermediates so a move below zero stays visible as negative.
  always_comb begin
    w_pos      = $signed({1'b0, i_pos});
    w_step     = $signed({7'b000_0000, i_step});
    w_max      = $signed({1'b0, i_max});
    w_cand     = w_pos;
    o_next     = i_pos;
    o_next_dir = i_dir;
    o_bounce   = 1'b0;
    if (i_step == 4'd0) begin
      // Zero step (also used for pause): hold position, no bounce.
      o_next     = i_pos;
      o_next_dir = i_dir;
      o_bounce   = 1'b0;
    end else if (i_auto) begin
      w_cand = i_dir ? (w_pos + w_step) : (w_pos - w_step);
      if (w_cand >= w_max) begin
        o_next     = i_max;
        o_next_dir = ~i_dir;
        o_bounce   = 1'b1;
      end else if (w_cand <= 11'sd0) begin
        o_next     = 10'd0;
        o_next_dir = ~i_dir;
        o_bounce   = 1'b1;
      end else begin
        o_next     = w_cand[9:0];
      end
    end else begin
      // Manual: opposing buttons cancel; clamping never bounces or flips.
      if (i_plus && !i_minus) begin
        w_cand = w_pos + w_step;
      end else if (i_minus && !i_plus) begin
        w_cand = w_pos - w_step;
      end else begin
        w_cand = w_pos;
      end
      if (w_cand > w_max) begin
        o_next = i_max;
      end else if (w_cand < 11'sd0) begin
        o_next = 10'd0;
      end else begin
        o_next = w_cand[9:0];
      end
    end
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Frame-synchronous sprite position controller: latch at frame start,
// compute into shadows, then commit, so a frame never sees a partial update.
module sprite_motion_ctrl
  import sprite_pkg::*;
#(
  parameter int H_ACTIVE_P = H_ACTIVE,
  parameter int V_ACTIVE_P = V_ACTIVE,
  parameter int SPRITE_W_P = SPRITE_W,
  parameter int SPRITE_H_P = SPRITE_H,
  parameter int X_INIT     = 288,
  parameter int Y_INIT     = 208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       mode,
  input  logic       pause,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic [3:0] step,
  output coord_t     posx,
  output coord_t     posy,
  output logic       bounce_x,
  output logic       bounce_y,
  output logic       overrun,
  output logic       busy
);

  localparam coord_t XMAX   = coord_t'(H_ACTIVE_P - SPRITE_W_P);
  localparam coord_t YMAX   = coord_t'(V_ACTIVE_P - SPRITE_H_P);
  localparam coord_t XSTART = coord_t'(X_INIT);
  localparam coord_t YSTART = coord_t'(Y_INIT);

  motion_state_t r_state, w_state_nxt;

  logic       r_mode, r_pause;
  logic [3:0] r_step;
  logic       r_up, r_down, r_left, r_right;
  coord_t     r_nx, r_ny;
  dir_t       r_ndx, r_ndy, r_dir_x, r_dir_y;
  logic       r_bx, r_by;

  logic [3:0] w_step_eff;
  coord_t     w_nx, w_ny;
  dir_t       w_ndx, w_ndy;
  logic       w_bx, w_by;

  assign w_step_eff = r_pause ? 4'd0 : r_step;

  axis_stepper u_axis_x (
    .i_pos      (posx),
    .i_step     (w_step_eff),
    .i_dir      (r_dir_x),
    .i_max      (XMAX),
    .i_auto     (r_mode),
    .i_plus     (r_right),
    .i_minus    (r_left),
    .o_next     (w_nx),
    .o_next_dir (w_ndx),
    .o_bounce   (w_bx)
  );

  axis_stepper u_axis_y (
    .i_pos      (posy),
    .i_step     (w_step_eff),
    .i_dir      (r_dir_y),
    .i_max      (YMAX),
    .i_auto     (r_mode),
    .i_plus     (r_down),
    .i_minus    (r_up),
    .o_next     (w_ny),
    .o_next_dir (w_ndy),
    .o_bounce   (w_by)
  );

  // Next-state logic: one cycle per state, frame start only accepted in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = frame_start ? CALC : IDLE;
      CALC:    w_state_nxt = COMMIT;
      COMMIT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Input latch, shadow computation, commit and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode   <= 1'b0;
      r_pause  <= 1'b0;
      r_step   <= 4'd0;
      r_up     <= 1'b0;
      r_down   <= 1'b0;
      r_left   <= 1'b0;
      r_right  <= 1'b0;
      r_nx     <= XSTART;
      r_ny     <= YSTART;
      r_ndx    <= 1'b1;
      r_ndy    <= 1'b1;
      r_bx     <= 1'b0;
      r_by     <= 1'b0;
      r_dir_x  <= 1'b1;
      r_dir_y  <= 1'b1;
      posx     <= XSTART;
      posy     <= YSTART;
      bounce_x <= 1'b0;
      bounce_y <= 1'b0;
      overrun  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      bounce_x <= 1'b0;
      bounce_y <= 1'b0;
      overrun  <= frame_start && (r_state != IDLE);
      busy     <= (w_state_nxt != IDLE);
      case (r_state)
        IDLE: begin
          if (frame_start) begin
            r_mode  <= mode;
            r_pause <= pause;
            r_step  <= step;
            r_up    <= btn_up;
            r_down  <= btn_down;
            r_left  <= btn_left;
            r_right <= btn_right;
          end
        end
        CALC: begin
          r_nx  <= w_nx;
          r_ny  <= w_ny;
          r_ndx <= w_ndx;
          r_ndy <= w_ndy;
          r_bx  <= w_bx;
          r_by  <= w_by;
        end
        COMMIT: begin
          posx     <= r_nx;
          posy     <= r_ny;
          r_dir_x  <= r_ndx;
          r_dir_y  <= r_ndy;
          bounce_x <= r_bx;
          bounce_y <= r_by;
        end
        default: begin
          r_mode <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Self-checking bench: directed scenarios plus random frames against a
// frame-level model of the sprite's position and direction.
module tb_sprite_motion_ctrl;

  localparam int XMAX = 576;
  localparam int YMAX = 416;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_start = 1'b0;
  logic       mode = 1'b0, pause = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [3:0] step = 4'd0;
  logic [9:0] posx, posy;
  logic       bounce_x, bounce_y, overrun, busy;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  int m_x = 288, m_y = 208;
  bit m_dx = 1'b1, m_dy = 1'b1;

  // Observed bounce of the last frame (for directed checks)
  bit last_bx, last_by;

  sprite_motion_ctrl dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .mode(mode), .pause(pause),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .step(step), .posx(posx), .posy(posy), .bounce_x(bounce_x), .bounce_y(bounce_y),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  // One axis, one frame, straight from the motion rules.
  function automatic void model_axis(input int pos, input int mx, input bit dir,
                                     input int st, input bit auto_m, input bit plus,
                                     input bit minus, output int np, output bit nd,
                                     output bit bn);
    int cand;
    np = pos; nd = dir; bn = 1'b0;
    if (st == 0) return;
    if (auto_m) begin
      cand = dir ? pos + st : pos - st;
      if (cand >= mx)     begin np = mx; nd = !dir; bn = 1'b1; end
      else if (cand <= 0) begin np = 0;  nd = !dir; bn = 1'b1; end
      else np = cand;
    end else begin
      cand = pos;
      if (plus && !minus) cand = pos + st;
      if (minus && !plus) cand = pos - st;
      np = (cand > mx) ? mx : (cand < 0) ? 0 : cand;
    end
  endfunction

  // b = {up, down, left, right}; late_step is driven once the frame is latched.
  task automatic run_frame(input bit m, input bit p, input logic [3:0] s,
                           input logic [3:0] b, input bit ovr, input logic [3:0] late_step);
    int ex, ey, ox, oy, se;
    bit edx, edy, ebx, eby;
    se = p ? 0 : int'(s);
    model_axis(m_x, XMAX, m_dx, se, m, b[0], b[1], ex, edx, ebx);
    model_axis(m_y, YMAX, m_dy, se, m, b[2], b[3], ey, edy, eby);
    ox = m_x; oy = m_y;
    @(negedge clk);
    mode = m; pause = p; step = s; {btn_up, btn_down, btn_left, btn_right} = b;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = ovr;
    mode = 1'($urandom); pause = 1'($urandom); step = late_step;
    {btn_up, btn_down, btn_left, btn_right} = 4'($urandom);
    n_cmp++;
    if ({busy, overrun, bounce_x, bounce_y, posx, posy} !== {4'b1000, 10'(ox), 10'(oy)}) begin
      n_fail++;
      $display("FAIL calc_stage busy=%0b ovr=%0b bx=%0b by=%0b pos=(%0d,%0d) want busy=1 ovr=0 bx=0 by=0 pos=(%0d,%0d)",
               busy, overrun, bounce_x, bounce_y, posx, posy, ox, oy);
    end
    @(negedge clk);
    frame_start = 1'b0;
    n_cmp++;
    if ({busy, overrun, bounce_x, bounce_y, posx, posy} !== {1'b1, ovr, 2'b00, 10'(ox), 10'(oy)}) begin
      n_fail++;
      $display("FAIL commit_stage busy=%0b ovr=%0b bx=%0b by=%0b pos=(%0d,%0d) want busy=1 ovr=%0b bx=0 by=0 pos=(%0d,%0d)",
               busy, overrun, bounce_x, bounce_y, posx, posy, ovr, ox, oy);
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, overrun, bounce_x, bounce_y, posx, posy} !== {2'b00, ebx, eby, 10'(ex), 10'(ey)}) begin
      n_fail++;
      $display("FAIL update busy=%0b ovr=%0b bx=%0b by=%0b pos=(%0d,%0d) want busy=0 ovr=0 bx=%0b by=%0b pos=(%0d,%0d)",
               busy, overrun, bounce_x, bounce_y, posx, posy, ebx, eby, ex, ey);
    end
    last_bx = bounce_x; last_by = bounce_y;
    m_x = ex; m_y = ey; m_dx = edx; m_dy = edy;
    @(negedge clk);
    n_cmp++;
    if ({busy, overrun, bounce_x, bounce_y, posx, posy} !== {4'b0000, 10'(ex), 10'(ey)}) begin
      n_fail++;
      $display("FAIL after_update busy=%0b ovr=%0b bx=%0b by=%0b pos=(%0d,%0d) want all 0 pos=(%0d,%0d)",
               busy, overrun, bounce_x, bounce_y, posx, posy, ex, ey);
    end
  endtask

  task automatic goto_x(input int tx);
    int d, mag;
    while (m_x != tx) begin
      d = tx - m_x; mag = (d < 0) ? -d : d;
      if (mag > 15) mag = 15;
      run_frame(1'b0, 1'b0, 4'(mag), (d > 0) ? 4'b0001 : 4'b0010, 1'b0, 4'($urandom));
    end
  endtask

  task automatic goto_y(input int ty);
    int d, mag;
    while (m_y != ty) begin
      d = ty - m_y; mag = (d < 0) ? -d : d;
      if (mag > 15) mag = 15;
      run_frame(1'b0, 1'b0, 4'(mag), (d > 0) ? 4'b0100 : 4'b1000, 1'b0, 4'($urandom));
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({posx, posy, busy, overrun, bounce_x, bounce_y} !== {10'd288, 10'd208, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_hold pos=(%0d,%0d) busy=%0b got, want (288,208) busy=0", posx, posy, busy);
    end
    rst = 1'b1;
    run_frame(1'b1, 1'b0, 4'd9, 4'b0000, 1'b0, 4'd9);
    // Start another frame and reset while it is in CALC.
    @(negedge clk);
    mode = 1'b1; pause = 1'b0; step = 4'd12; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({posx, posy, busy} !== {10'd288, 10'd208, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_midcalc pos=(%0d,%0d) busy=%0b got, want (288,208) busy=0", posx, posy, busy);
    end
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({posx, posy, busy, overrun, bounce_x, bounce_y} !== {10'd288, 10'd208, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_release pos=(%0d,%0d) busy=%0b ovr=%0b got, want (288,208) 0 0", posx, posy, busy, overrun);
    end
    m_x = 288; m_y = 208; m_dx = 1'b1; m_dy = 1'b1;
    run_frame(1'b1, 1'b1, 4'd6, 4'b0000, 1'b0, 4'd3);
  endtask

  task automatic test_right_wall;
    goto_x(574);
    run_frame(1'b1, 1'b0, 4'd2, 4'b0000, 1'b0, 4'd2);
    n_cmp++;
    if (posx !== 10'd576 || last_bx !== 1'b1) begin
      n_fail++;
      $display("FAIL right_wall posx=%0d bx=%0b got, want 576 1", posx, last_bx);
    end
    run_frame(1'b1, 1'b0, 4'd2, 4'b0000, 1'b0, 4'd2);
    n_cmp++;
    if (posx !== 10'd574 || last_bx !== 1'b0) begin
      n_fail++;
      $display("FAIL right_wall_back posx=%0d bx=%0b got, want 574 0", posx, last_bx);
    end
  endtask

  task automatic test_top_wall;
    goto_y(416);
    run_frame(1'b1, 1'b0, 4'd1, 4'b0000, 1'b0, 4'd1);  // bottom bounce turns dir_y negative
    goto_y(3);
    run_frame(1'b1, 1'b0, 4'd5, 4'b0000, 1'b0, 4'd5);
    n_cmp++;
    if (posy !== 10'd0 || last_by !== 1'b1) begin
      n_fail++;
      $display("FAIL top_wall posy=%0d by=%0b got, want 0 1", posy, last_by);
    end
    run_frame(1'b1, 1'b0, 4'd5, 4'b0000, 1'b0, 4'd5);
    n_cmp++;
    if (posy !== 10'd5) begin
      n_fail++;
      $display("FAIL top_wall_back posy=%0d got, want 5", posy);
    end
  endtask

  task automatic test_manual_clamp;
    int x0;
    goto_y(414);
    x0 = m_x;
    run_frame(1'b0, 1'b0, 4'd4, 4'b0111, 1'b0, 4'd4);
    n_cmp++;
    if (posx !== 10'(x0) || posy !== 10'd416 || last_bx || last_by) begin
      n_fail++;
      $display("FAIL manual_clamp pos=(%0d,%0d) b=%0b%0b got, want (%0d,416) 00", posx, posy, last_bx, last_by, x0);
    end
    run_frame(1'b0, 1'b0, 4'd4, 4'b0100, 1'b0, 4'd4);
    n_cmp++;
    if (posy !== 10'd416 || last_by) begin
      n_fail++;
      $display("FAIL manual_hold posy=%0d by=%0b got, want 416 0", posy, last_by);
    end
  endtask

  task automatic test_overrun;
    int x0;
    goto_x(300);
    x0 = m_x;
    run_frame(1'b0, 1'b0, 4'd3, 4'b0001, 1'b1, 4'd3);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (posx !== 10'(x0 + 3) || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_single posx=%0d busy=%0b got, want %0d 0", posx, busy, x0 + 3);
    end
  endtask

  task automatic test_step_latch;
    int x0;
    goto_x(100);
    x0 = m_x;
    run_frame(1'b0, 1'b0, 4'd2, 4'b0001, 1'b0, 4'd7);
    n_cmp++;
    if (posx !== 10'(x0 + 2)) begin
      n_fail++;
      $display("FAIL step_latch_cur posx=%0d got, want %0d", posx, x0 + 2);
    end
    run_frame(1'b0, 1'b0, 4'd7, 4'b0001, 1'b0, 4'd0);
    n_cmp++;
    if (posx !== 10'(x0 + 9)) begin
      n_fail++;
      $display("FAIL step_latch_next posx=%0d got, want %0d", posx, x0 + 9);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 60; i++) begin
      run_frame(1'($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0),
                4'($urandom), 4'($urandom), ($urandom_range(0, 5) == 0), 4'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_right_wall;
    test_top_wall;
    test_manual_clamp;
    test_overrun;
    test_step_latch;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
